// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan controller: segment bit positions,
// the active-high hex glyph table and the digit-index width helper.
package sseg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Glyphs as {g,f,e,d,c,b,a}, active-high; entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam int DEFAULT_DIGITS = 4;

    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    localparam int IDX_W = idx_width(DEFAULT_DIGITS);

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to seven-segment glyph lookup (active-high, no dp).
module hex7seg
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// N-digit seven-segment scan controller with prescaler, anti-ghost blanking,
// tear-free frame-aligned value update and frame sync. Optional SSEG_LZB_EN.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIV_W          = 16,
    parameter int BLANK_CYC      = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int IW = idx_width(DIGITS);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    logic [DIV_W-1:0]    presc;
    logic [IW-1:0]       idx;
    logic [DIV_W-1:0]    blank_cnt;
    logic                run;
    logic [4*DIGITS-1:0] staging_val, shadow_val;
    logic [DIGITS-1:0]   staging_dp, shadow_dp;
    logic                pending;

    logic                tick, wrap;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic [6:0]          glyph;
    logic                digit_vis;
    logic                show;
    logic [DIGITS-1:0]   an_raw;
    logic [7:0]          seg_raw;

    assign tick = &presc;
    assign wrap = tick && (idx == LAST);

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib = shadow_val[4*i +: 4];
                cur_dp  = shadow_dp[i];
            end
        end
    end

    hex7seg u_hex7seg (
        .nibble (cur_nib),
        .segs   (glyph)
    );

`ifdef SSEG_LZB_EN
    logic [IW-1:0] msd;
    always_comb begin
        msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (shadow_val[4*i +: 4] != 4'h0) msd = IW'(i);
        end
    end
    assign digit_vis = (idx <= msd);
`else
    assign digit_vis = 1'b1;
`endif

    // Nothing is driven until the first scan tick, so the first lit digit is 1.
    assign show = run && (blank_cnt == '0) && digit_vis;

    always_comb begin
        an_raw  = '0;
        seg_raw = '0;
        if (show) begin
            an_raw          = DIGITS'(1) << idx;
            seg_raw[6:0]    = glyph;
            seg_raw[SEG_DP] = cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc       <= '0;
            idx         <= '0;
            blank_cnt   <= '0;
            run         <= 1'b0;
            staging_val <= '0;
            staging_dp  <= '0;
            shadow_val  <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
            an          <= AN_ACTIVE_LOW ? '1 : '0;
            seg         <= SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
            frame_done  <= 1'b0;
        end else begin
            presc      <= presc + 1'b1;
            frame_done <= wrap;

            if (tick) begin
                idx       <= wrap ? '0 : idx + 1'b1;
                blank_cnt <= DIV_W'(BLANK_CYC);
                run       <= 1'b1;
            end else if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - 1'b1;
            end

            if (load) begin
                staging_val <= value;
                staging_dp  <= dp_in;
            end

            // Shadow only changes at the frame boundary; a load on that same
            // cycle bypasses staging so it is not deferred a whole frame.
            if (wrap) begin
                if (load) begin
                    shadow_val <= value;
                    shadow_dp  <= dp_in;
                end else if (pending) begin
                    shadow_val <= staging_val;
                    shadow_dp  <= staging_dp;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            an  <= AN_ACTIVE_LOW  ? ~an_raw  : an_raw;
            seg <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        end
    end

endmodule
